pc_gen_unit: RTL and testbench

Parametrised program-counter generator. Successor to the single-register PC stage.
Holds the fetch PC and presents it to the instruction-fetch stage through a valid/ready handshake. Advances sequentially on each accepted fetch and applies trap or branch redirects with fixed priority.
Supports halt/resume and tags every PC with an epoch count, so fetches that were already in flight before a redirect can be discarded downstream.

---
 rtl/pc_gen_unit.sv | 104 ++++++++++
 tb/tb_pc_gen_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - program-counter generator with valid/ready fetch handshake, trap/redirect priority and epoch tagging
// Optional misaligned-redirect correction enabled by PCGEN_ALIGN_CHECK_EN.
module pc_gen_unit #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VEC   = 32'h0000_0100,
    parameter int               INST_BYTES = 4,
    parameter int               EPOCH_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_ready,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_target,
    input  logic                trap_valid,
    input  logic                halt_req,
    output logic [XLEN-1:0]     pc,
    output logic                pc_valid,
    output logic [EPOCH_W-1:0]  pc_epoch,
    output logic                align_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]    STEP      = XLEN'(INST_BYTES);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

    state_t          state;
    logic            fire;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_misaligned;

    assign fire   = pc_valid & pc_ready;
    assign pc_seq = pc + STEP;

`ifdef PCGEN_ALIGN_CHECK_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    assign redirect_pc         = redirect_target & ~ALIGN_MASK;
    assign redirect_misaligned = |(redirect_target & ALIGN_MASK);
`else
    assign redirect_pc         = redirect_target;
    assign redirect_misaligned = 1'b0;
`endif

    // Trap beats redirect beats halt beats sequential advance; every branch is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_VEC;
            pc_valid  <= 1'b0;
            pc_epoch  <= '0;
            align_err <= 1'b0;
        end else begin
            align_err <= 1'b0;
            case (state)
                ST_BOOT: begin
                    if (halt_req) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                    end else begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end
                end
                ST_RUN, ST_HALT: begin
                    if (trap_valid) begin
                        pc       <= TRAP_VEC;
                        pc_epoch <= pc_epoch + EPOCH_ONE;
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end else if (redirect_valid) begin
                        pc        <= redirect_pc;
                        pc_epoch  <= pc_epoch + EPOCH_ONE;
                        state     <= ST_RUN;
                        pc_valid  <= 1'b1;
                        align_err <= redirect_misaligned;
                    end else if (state == ST_RUN && halt_req) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                        if (fire) begin
                            pc <= pc_seq;
                        end
                    end else if (state == ST_HALT && !halt_req) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end else if (fire) begin
                        pc <= pc_seq;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - directed self-checking bench for pc_gen_unit
module tb_pc_gen_unit;

    logic        clk;
    logic        rst;
    logic        pc_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  pc_epoch;
    logic        align_err;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_ready        (pc_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_epoch        (pc_epoch),
        .align_err       (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; pc_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_tests++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        n_tests++; if (pc_epoch !== 2'd0) begin n_fail++; $display("FAIL reset_epoch: got %0d want 0", pc_epoch); end
        n_tests++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_align: got %b want 0", align_err); end
        rst = 1'b1;
        #1;
        n_tests++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
        tick;
        n_tests++; if (pc_valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL run_first: valid %b pc %h want 1 00000000", pc_valid, pc); end
        tick;
        n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL seq_4: got %h want 00000004", pc); end
        tick;
        n_tests++; if (pc !== 32'h8 || pc_epoch !== 2'd0) begin n_fail++; $display("FAIL seq_8: pc %h epoch %0d want 00000008 0", pc, pc_epoch); end
    endtask

    task automatic test_stall;
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_tests++; if (pc !== 32'h8 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL stall_%0d: pc %h valid %b want 00000008 1", i, pc, pc_valid); end
        end
        pc_ready = 1'b1;
        tick;
        n_tests++; if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_release: got %h want 0000000c", pc); end
    endtask

    task automatic test_priority;
        redirect_valid = 1'b1; redirect_target = 32'h200; trap_valid = 1'b1;
        tick;
        n_tests++; if (pc !== 32'h100 || pc_epoch !== 2'd1) begin n_fail++; $display("FAIL trap_wins: pc %h epoch %0d want 00000100 1", pc, pc_epoch); end
        trap_valid = 1'b0; pc_ready = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h200 || pc_epoch !== 2'd2 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_noready: pc %h epoch %0d valid %b want 00000200 2 1", pc, pc_epoch, pc_valid); end
        redirect_valid = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h200) begin n_fail++; $display("FAIL hold_after_redirect: got %h want 00000200", pc); end
    endtask

    task automatic test_boot_ignore;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h500; trap_valid = 1'b1; pc_ready = 1'b1;
        tick;
        n_tests++; if (pc !== 32'h0 || pc_epoch !== 2'd0 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL boot_ignore: pc %h epoch %0d valid %b want 00000000 0 1", pc, pc_epoch, pc_valid); end
        redirect_valid = 1'b0; trap_valid = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h4 || pc_epoch !== 2'd0) begin n_fail++; $display("FAIL boot_then_seq: pc %h epoch %0d want 00000004 0", pc, pc_epoch); end
    endtask

    task automatic test_epoch_wrap;
        logic [1:0]  exp_epoch [4];
        logic [31:0] tgt;
        exp_epoch[0] = 2'd1; exp_epoch[1] = 2'd2; exp_epoch[2] = 2'd3; exp_epoch[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tgt = 32'h300 + 32'(4 * i);
            redirect_valid = 1'b1; redirect_target = tgt;
            tick;
            n_tests++; if (pc !== tgt || pc_epoch !== exp_epoch[i]) begin n_fail++; $display("FAIL epoch_wrap_%0d: pc %h epoch %0d want %h %0d", i, pc, pc_epoch, tgt, exp_epoch[i]); end
        end
        redirect_target = 32'hFFFF_FFFC;
        tick;
        n_tests++; if (pc !== 32'hFFFF_FFFC || pc_epoch !== 2'd1) begin n_fail++; $display("FAIL wrap_setup: pc %h epoch %0d want fffffffc 1", pc, pc_epoch); end
        redirect_valid = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h0 || pc_epoch !== 2'd1) begin n_fail++; $display("FAIL pc_wrap: pc %h epoch %0d want 00000000 1", pc, pc_epoch); end
    endtask

    task automatic test_halt;
        halt_req = 1'b1;
        tick;
        n_tests++; if (pc !== 32'h4 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: pc %h valid %b want 00000004 0", pc, pc_valid); end
        tick;
        n_tests++; if (pc !== 32'h4 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: pc %h valid %b want 00000004 0", pc, pc_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick;
        n_tests++; if (pc !== 32'h40 || pc_valid !== 1'b1 || pc_epoch !== 2'd2) begin n_fail++; $display("FAIL halt_redirect: pc %h valid %b epoch %0d want 00000040 1 2", pc, pc_valid, pc_epoch); end
        redirect_valid = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h44 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL rehalt: pc %h valid %b want 00000044 0", pc, pc_valid); end
        halt_req = 1'b0;
        tick;
        n_tests++; if (pc !== 32'h44 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL resume: pc %h valid %b want 00000044 1", pc, pc_valid); end
        tick;
        n_tests++; if (pc !== 32'h48) begin n_fail++; $display("FAIL resume_seq: got %h want 00000048", pc); end
    endtask

    task automatic test_align;
        logic [31:0] exp_pc;
        logic        exp_err;
`ifdef PCGEN_ALIGN_CHECK_EN
        exp_pc = 32'h100; exp_err = 1'b1;
`else
        exp_pc = 32'h102; exp_err = 1'b0;
`endif
        redirect_valid = 1'b1; redirect_target = 32'h102;
        tick;
        n_tests++; if (pc !== exp_pc || align_err !== exp_err || pc_epoch !== 2'd3) begin n_fail++; $display("FAIL align_redirect: pc %h err %b epoch %0d want %h %b 3", pc, align_err, pc_epoch, exp_pc, exp_err); end
        redirect_valid = 1'b0; pc_ready = 1'b0;
        tick;
        n_tests++; if (align_err !== 1'b0 || pc !== exp_pc) begin n_fail++; $display("FAIL align_pulse: err %b pc %h want 0 %h", align_err, pc, exp_pc); end
    endtask

    task automatic test_async_reset;
        pc_ready = 1'b1;
        tick;
        rst = 1'b0;
        #2;
        n_tests++; if (pc !== 32'h0 || pc_valid !== 1'b0 || pc_epoch !== 2'd0 || align_err !== 1'b0) begin n_fail++; $display("FAIL async_reset: pc %h valid %b epoch %0d err %b want 00000000 0 0 0", pc, pc_valid, pc_epoch, align_err); end
        rst = 1'b1;
        tick;
        n_tests++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL after_reset: pc %h valid %b want 00000000 1", pc, pc_valid); end
    endtask

    initial begin
        test_reset;
        test_stall;
        test_priority;
        test_boot_ignore;
        test_epoch_wrap;
        test_halt;
        test_align;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
